// File: rtl/operand_fetch_if.sv
// Bundle of the operand_fetch handshake, GRF read and writeback signals.
// The slave modport is the stage's view; master is the surrounding core.
interface operand_fetch_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [31:0] in_pc;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic        wb_we;
    logic [4:0]  wb_a3;
    logic [31:0] wb_wd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rs_val;
    logic [31:0] out_rt_val;
    logic [4:0]  out_rd;
    logic        sb_err;

    modport slave (
        input  in_valid, in_rs, in_rt, in_rd, in_pc, RD1, RD2,
        input  wb_we, wb_a3, wb_wd, flush, out_ready,
        output in_ready, A1, A2, out_valid, out_pc, out_rs_val, out_rt_val, out_rd, sb_err
    );

    modport master (
        output in_valid, in_rs, in_rt, in_rd, in_pc, RD1, RD2,
        output wb_we, wb_a3, wb_wd, flush, out_ready,
        input  in_ready, A1, A2, out_valid, out_pc, out_rs_val, out_rt_val, out_rd, sb_err
    );
endinterface

// File: rtl/operand_fetch.sv
// Decode-to-execute operand stage with a per-register pending-writeback scoreboard.
// Define OPERAND_FWD_EN to compile in the same-cycle writeback bypass.
module operand_fetch #(
    parameter int PEND_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    operand_fetch_if.slave  bus
);

    localparam logic [PEND_W-1:0] CNT_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] CNT_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] CNT_ZERO = {PEND_W{1'b0}};

    logic [PEND_W-1:0] cnt_r [1:31];
    logic              out_valid_r;
    logic [31:0]       out_pc_r;
    logic [31:0]       out_rs_val_r;
    logic [31:0]       out_rt_val_r;
    logic [4:0]        out_rd_r;
    logic              sb_err_r;

    logic              fwd_rs_s;
    logic              fwd_rt_s;
    logic              stall_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              sb_hit_s;
    logic [31:0]       rs_val_s;
    logic [31:0]       rt_val_s;

    // Register 0 has no scoreboard entry and always reads as idle.
    function automatic logic [PEND_W-1:0] cnt_at(input logic [4:0] idx);
        if (idx == 5'd0) begin
            return CNT_ZERO;
        end else begin
            return cnt_r[idx];
        end
    endfunction

    // Net of one increment and up to two decrements, floored at zero.
    function automatic logic [PEND_W-1:0] cnt_next(input logic [PEND_W-1:0] c,
                                                   input logic inc, input logic dwb,
                                                   input logic dfl);
        logic [PEND_W:0] up_s;
        logic [PEND_W:0] dn_s;
        logic [PEND_W:0] diff_s;
        up_s   = {1'b0, c} + {{PEND_W{1'b0}}, inc};
        dn_s   = {{PEND_W{1'b0}}, dwb} + {{PEND_W{1'b0}}, dfl};
        diff_s = up_s - dn_s;
        if (up_s > dn_s) begin
            return diff_s[PEND_W-1:0];
        end else begin
            return CNT_ZERO;
        end
    endfunction

    // Hazard detection, operand selection and the input handshake.
    always_comb begin
        fwd_rs_s = 1'b0;
        fwd_rt_s = 1'b0;
`ifdef OPERAND_FWD_EN
        fwd_rs_s = bus.wb_we && (bus.wb_a3 == bus.in_rs) && (cnt_at(bus.in_rs) == CNT_ONE);
        fwd_rt_s = bus.wb_we && (bus.wb_a3 == bus.in_rt) && (cnt_at(bus.in_rt) == CNT_ONE);
`else
        fwd_rs_s = 1'b0;
        fwd_rt_s = 1'b0;
`endif
        stall_s = 1'b0;
        if ((cnt_at(bus.in_rs) != CNT_ZERO) && !fwd_rs_s) begin
            stall_s = 1'b1;
        end else if ((cnt_at(bus.in_rt) != CNT_ZERO) && !fwd_rt_s) begin
            stall_s = 1'b1;
        end else if (bus.in_rd != 5'd0 && cnt_at(bus.in_rd) == CNT_MAX) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
        in_ready_s = !bus.flush && (!out_valid_r || bus.out_ready) && !stall_s;
        accept_s   = bus.in_valid && in_ready_s;

        if (bus.in_rs == 5'd0) begin
            rs_val_s = 32'd0;
        end else if (fwd_rs_s) begin
            rs_val_s = bus.wb_wd;
        end else begin
            rs_val_s = bus.RD1;
        end
        if (bus.in_rt == 5'd0) begin
            rt_val_s = 32'd0;
        end else if (fwd_rt_s) begin
            rt_val_s = bus.wb_wd;
        end else begin
            rt_val_s = bus.RD2;
        end

        // A same-edge issue to the register legitimises the writeback.
        sb_hit_s = bus.wb_we && (bus.wb_a3 != 5'd0) && (cnt_at(bus.wb_a3) == CNT_ZERO)
                   && !(accept_s && bus.in_rd == bus.wb_a3);
    end

    // Scoreboard counters and the sticky scoreboard error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 1; r < 32; r++) begin
                cnt_r[r] <= CNT_ZERO;
            end
            sb_err_r <= 1'b0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                cnt_r[r] <= cnt_next(cnt_r[r],
                                     accept_s && (bus.in_rd == 5'(r)),
                                     bus.wb_we && (bus.wb_a3 == 5'(r)),
                                     bus.flush && out_valid_r && (out_rd_r == 5'(r)));
            end
            if (sb_hit_s) begin
                sb_err_r <= 1'b1;
            end else begin
                sb_err_r <= sb_err_r;
            end
        end
    end

    // Execute-side output register; flush wins over consume and never accepts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_r  <= 1'b0;
            out_pc_r     <= 32'd0;
            out_rs_val_r <= 32'd0;
            out_rt_val_r <= 32'd0;
            out_rd_r     <= 5'd0;
        end else if (bus.flush) begin
            out_valid_r  <= 1'b0;
        end else if (accept_s) begin
            out_valid_r  <= 1'b1;
            out_pc_r     <= bus.in_pc;
            out_rs_val_r <= rs_val_s;
            out_rt_val_r <= rt_val_s;
            out_rd_r     <= bus.in_rd;
        end else if (bus.out_ready) begin
            out_valid_r  <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_r;
        end
    end

    assign bus.A1         = bus.in_rs;
    assign bus.A2         = bus.in_rt;
    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_pc     = out_pc_r;
    assign bus.out_rs_val = out_rs_val_r;
    assign bus.out_rt_val = out_rt_val_r;
    assign bus.out_rd     = out_rd_r;
    assign bus.sb_err     = sb_err_r;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode-to-execute operand stage for the multi-cycle/pipelined MIPS core. It accepts one decoded instruction per handshake and drives the GRF read addresses for that instruction's rs and rt. A per-register scoreboard of pending writebacks blocks RAW hazards, and the selected operands, PC and destination are registered for the execute stage behind a valid/ready handshake. It sits on the consumer side of the GRF read ports and observes the same writeback bus (WE/A3/WD3) that drives the GRF write port.

## Interface
- PEND_W, 2, width of each per-register pending-write counter (max in flight per register = 2^PEND_W-1)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_rs, in_rt  in  5 each  source register indices (0 = unused/zero)
- in_rd  in  5  destination register index (0 = no write)
- in_pc  in  32  instruction PC
- A1, A2  out  5 each  GRF read addresses; combinationally equal to in_rs, in_rt
- RD1, RD2  in  32 each  GRF read data (combinational from A1/A2)
- wb_we, wb_a3, wb_wd  in  1/5/32  writeback bus, same signals as the GRF write port
- flush  in  1  discard the instruction held in the output register
- out_valid  out  1  operands valid for execute
- out_ready  in  1  execute consumes this cycle
- out_pc, out_rs_val, out_rt_val  out  32 each  registered PC and operands
- out_rd  out  5  registered destination
- sb_err  out  1  sticky: writeback seen for a register with zero pending count

## Operation
- Scoreboard: cnt[r] for r = 1..31, each PEND_W bits wide; cnt[0] is constant 0.
- Source hazard for rs: in_rs≠0 and cnt[in_rs]≠0, and not forwardable. The rt hazard uses the same rule.
- Forwardable (FWD_EN only): wb_we, wb_a3==src, and cnt[src]==1, i.e. the only pending write completes this cycle.
- Destination stall: in_rd≠0 and cnt[in_rd] == 2^PEND_W-1.
- in_ready = !flush and (!out_valid or out_ready) and no source hazard and no destination stall.
- Accept = in_valid and in_ready. On accept the output register loads:
  - out_pc ← in_pc, out_rd ← in_rd.
  - Each operand value is 0 if its index is 0, otherwise the forwarded wb_wd, otherwise RD1/RD2.
- Counter update per register per edge:
  - +1 on accept with in_rd == r.
  - −1 on wb_we with wb_a3 == r.
  - −1 on flush while out_valid with out_rd == r.
  - Net result saturates at 0. Increment plus one decrement leaves the count unchanged.
- Writeback to r with cnt[r]==0 and no same-edge increment is ignored and sets sb_err. sb_err clears only on reset.
- wb_a3==0 never affects the scoreboard.
- out_valid: set on accept, cleared on out_ready without accept, cleared on flush. flush beats out_ready; flush never accepts.

## Timing
- Reset (async, reset==0): out_valid=0, out_pc=out_rs_val=out_rt_val=0, out_rd=0, all cnt=0, sb_err=0. in_ready follows its equation immediately, so it is 1 after reset when flush=0.
- Latency: one cycle from accept to out_valid. Full throughput of one per cycle when out_ready is held high and there are no hazards.
- Output fields stay stable while out_valid and !out_ready.
- Writeback visibility:
  - The GRF commits at the same edge that clears the pending count.
  - Without forwarding, the dependent instruction issues on the following cycle and reads the committed value from RD1/RD2.
- Reset asserted mid-operation drops the held instruction and all pending counts. Writebacks that arrive after reset releases hit zero counts and set sb_err, which is intended to flag a broken reset domain.

## Configuration
- OPERAND_FWD_EN defined: the writeback bypass above is compiled in, so a dependent instruction may issue in the same cycle as its producer's writeback.
- OPERAND_FWD_EN undefined: there is no bypass, and any nonzero cnt[src] stalls. The dependent instruction issues one cycle later, with operands taken only from RD1/RD2.

## Test plan
- Reset release, then accept rs=1, rt=2, rd=3, pc=0x3000 with RD1=5, RD2=7 → next cycle out_valid=1, out_rs_val=5, out_rt_val=7, out_rd=3, cnt[3]=1.
- Issue rd=8. Next instruction has rs=8; wb_we, wb_a3=8, wb_wd=0x1234 arrive 3 cycles later:
  - FWD_EN: in_ready=0 until the wb cycle, accept in the wb cycle, out_rs_val=0x1234.
  - Without FWD_EN: accept one cycle later, operand taken from RD1.
- Three issues to rd=5 with out_ready=1 → cnt[5]=3 and a fourth issue to rd=5 stalls. One wb to 5 → the fourth issue is accepted in the next cycle.
- out_valid with out_rd=9, then assert flush together with in_valid → out_valid=0, cnt[9] back to 0, no accept that cycle.
- wb_we, wb_a3=4 with cnt[4]=0 → sb_err=1, which persists until reset. wb_a3=0 → no scoreboard change.
- rs=0 with RD1=0xFFFF_FFFF driven → out_rs_val=0 and no stall regardless of any pending writes to register 0.
